// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates data- and instruction-cache word requests onto one RAM port, data first.
// Define ARB_FAIR_EN to force an instruction grant after STARVE_MAX data grants while iREN waits.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        dwait,
  output logic        iwait,
  output logic [31:0] dload,
  output logic [31:0] iload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore
);
  typedef enum logic [1:0] {IDLE, DSERVE, ISERVE} state_e;
  localparam logic [1:0] ACCESS = 2'd2;
  if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_param
    $error("STARVE_MAX must fit the 3-bit starvation counter");
  end
  state_e state_q, state_d;
  logic dreq, dack, iack, starve;
  assign dreq = dREN | dWEN;
  assign dack = state_q == DSERVE && dreq && ramstate == ACCESS;
  assign iack = state_q == ISERVE && iREN && ramstate == ACCESS;
  assign dload = ramload;
  assign iload = ramload;
`ifdef ARB_FAIR_EN
  logic [2:0] cnt_q, cnt_d;
  assign starve = iREN && cnt_q == 3'(STARVE_MAX);
  assign cnt_d = (!iREN || iack) ? 3'd0 : dack ? cnt_q + 3'd1 : cnt_q;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= 3'd0;
    else cnt_q <= cnt_d;
  end
`else
  assign starve = 1'b0;
`endif
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else state_q <= state_d;
  end
  // A dropped request zeroes the bus and returns to IDLE in the same cycle.
  always_comb begin
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    dwait    = dreq;
    iwait    = iREN;
    case (state_q)
      IDLE:    state_d = starve ? ISERVE : dreq ? DSERVE : iREN ? ISERVE : IDLE;
      DSERVE: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = dreq ? daddr : 32'd0;
        ramstore = dreq ? dstore : 32'd0;
        dwait    = dreq & ~dack;
        state_d  = (!dreq || dack) ? IDLE : DSERVE;
      end
      ISERVE: begin
        ramREN  = iREN;
        ramaddr = iREN ? iaddr : 32'd0;
        iwait   = iREN & ~iack;
        state_d = (!iREN || iack) ? IDLE : ISERVE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: per-cycle vector table plus reset-abort and fairness sequences.
module tb_mem_arbiter;
  logic        CLK, nRST, dREN, dWEN, iREN;
  logic [31:0] daddr, dstore, iaddr, ramload;
  logic [1:0]  ramstate;
  logic        dwait, iwait, ramREN, ramWEN;
  logic [31:0] dload, iload, ramaddr, ramstore;
  int total = 0, bad = 0;

  localparam logic [1:0] F = 2'd0, B = 2'd1, A = 2'd2, E = 2'd3;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iREN(iREN), .iaddr(iaddr), .ramload(ramload), .ramstate(ramstate),
    .dwait(dwait), .iwait(iwait), .dload(dload), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        dren, dwen, iren;
    logic [31:0] daddr, dstore, iaddr, rload;
    logic [1:0]  rs;
    logic        edw, eiw, eren, ewen;
    logic [31:0] eaddr, estore;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(logic dr, logic dw, logic ir, logic [31:0] da, logic [31:0] ds,
                              logic [31:0] ia, logic [31:0] rl, logic [1:0] rs, logic edw,
                              logic eiw, logic eren, logic ewen, logic [31:0] ea, logic [31:0] es);
    vec_t t;
    t.dren = dr; t.dwen = dw; t.iren = ir; t.daddr = da; t.dstore = ds; t.iaddr = ia;
    t.rload = rl; t.rs = rs; t.edw = edw; t.eiw = eiw; t.eren = eren; t.ewen = ewen;
    t.eaddr = ea; t.estore = es;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic dr, input logic dw, input logic ir, input logic [31:0] da,
                       input logic [31:0] ds, input logic [31:0] ia, input logic [31:0] rl,
                       input logic [1:0] rs);
    dREN = dr; dWEN = dw; iREN = ir; daddr = da; dstore = ds; iaddr = ia; ramload = rl;
    ramstate = rs;
  endtask

  task automatic chk_bus(input string tag, input logic edw, input logic eiw, input logic eren,
                         input logic ewen, input logic [31:0] ea, input logic [31:0] es);
    chk({tag, "_dwait"}, 32'(dwait), 32'(edw));
    chk({tag, "_iwait"}, 32'(iwait), 32'(eiw));
    chk({tag, "_ramREN"}, 32'(ramREN), 32'(eren));
    chk({tag, "_ramWEN"}, 32'(ramWEN), 32'(ewen));
    chk({tag, "_ramaddr"}, ramaddr, ea);
    chk({tag, "_ramstore"}, ramstore, es);
    chk({tag, "_dload"}, dload, ramload);
    chk({tag, "_iload"}, iload, ramload);
  endtask

  initial begin
    logic [31:0] fair_addr [12];
    v.push_back(mk(1,0,0, 32'h40,0,0, 32'hDEADBEEF, B, 1,0,0,0, 0,0));
    v.push_back(mk(1,0,0, 32'h40,0,0, 32'hDEADBEEF, A, 0,0,1,0, 32'h40,0));
    v.push_back(mk(0,0,0, 0,0,0, 32'h11111111, F, 0,0,0,0, 0,0));
    v.push_back(mk(1,0,1, 32'h100,0,32'h200, 0, B, 1,1,0,0, 0,0));
    for (int k = 0; k < 3; k++)
      v.push_back(mk(1,0,1, 32'h100,0,32'h200, 32'h22220000 + k, B, 1,1,1,0, 32'h100,0));
    v.push_back(mk(1,0,1, 32'h100,0,32'h200, 32'hA5A5A5A5, A, 0,1,1,0, 32'h100,0));
    v.push_back(mk(0,0,1, 32'h100,0,32'h200, 0, A, 0,1,0,0, 0,0));
    v.push_back(mk(0,0,1, 32'h100,0,32'h200, 0, B, 0,1,1,0, 32'h200,0));
    v.push_back(mk(0,0,1, 32'h100,0,32'h200, 32'h5A5A5A5A, A, 0,0,1,0, 32'h200,0));
    v.push_back(mk(1,1,0, 32'h300,32'h12345678,0, 0, B, 1,0,0,0, 0,0));
    v.push_back(mk(1,1,0, 32'h300,32'h12345678,0, 0, E, 1,0,0,1, 32'h300,32'h12345678));
    v.push_back(mk(1,1,0, 32'h300,32'h12345678,0, 0, F, 1,0,0,1, 32'h300,32'h12345678));
    v.push_back(mk(1,1,0, 32'h300,32'h12345678,0, 0, A, 0,0,0,1, 32'h300,32'h12345678));
    v.push_back(mk(0,0,1, 0,0,32'h400, 0, B, 0,1,0,0, 0,0));
    v.push_back(mk(1,0,1, 32'h500,0,32'h400, 0, B, 1,1,1,0, 32'h400,0));
    v.push_back(mk(1,0,0, 32'h500,0,32'h400, 0, B, 1,0,0,0, 0,0));
    v.push_back(mk(1,0,0, 32'h500,0,32'h400, 0, B, 1,0,0,0, 0,0));
    v.push_back(mk(1,0,0, 32'h500,0,32'h400, 32'h77777777, A, 0,0,1,0, 32'h500,0));
    v.push_back(mk(0,0,0, 0,0,0, 0, F, 0,0,0,0, 0,0));
    v.push_back(mk(1,0,1, 32'h600,0,32'h800, 0, B, 1,1,0,0, 0,0));
    v.push_back(mk(1,0,1, 32'h600,0,32'h800, 32'h60006000, A, 0,1,1,0, 32'h600,0));
    v.push_back(mk(1,0,1, 32'h604,0,32'h800, 0, B, 1,1,0,0, 0,0));
    v.push_back(mk(1,0,1, 32'h604,0,32'h800, 32'h60406040, A, 0,1,1,0, 32'h604,0));
    v.push_back(mk(0,0,0, 0,0,0, 0, F, 0,0,0,0, 0,0));

    nRST = 1'b0;
    drive(1,1,1, 32'h40,32'h99,32'h80, 32'h33333333, A);
    #3 chk_bus("reset", 1,1,0,0, 0,0);
    drive(0,0,0, 0,0,0, 0, F);
    @(negedge CLK) nRST = 1'b1;

    foreach (v[i]) begin
      @(posedge CLK);
      #1 drive(v[i].dren, v[i].dwen, v[i].iren, v[i].daddr, v[i].dstore, v[i].iaddr,
               v[i].rload, v[i].rs);
      #3 chk_bus($sformatf("v%0d", i), v[i].edw, v[i].eiw, v[i].eren, v[i].ewen,
                 v[i].eaddr, v[i].estore);
    end

    @(posedge CLK);
    #1 drive(1,0,0, 32'h900,0,0, 0, B);
    #3 chk_bus("rst_idle", 1,0,0,0, 0,0);
    @(posedge CLK);
    #4 chk_bus("rst_dserve", 1,0,1,0, 32'h900,0);
    #1 nRST = 1'b0;
    #1 chk_bus("rst_abort", 1,0,0,0, 0,0);
    @(posedge CLK);
    #1 nRST = 1'b1;
    #3 chk_bus("rst_rearb", 1,0,0,0, 0,0);
    @(posedge CLK);
    #1 drive(1,0,0, 32'h900,0,0, 32'hCAFEF00D, A);
    #3 chk_bus("rst_done", 0,0,1,0, 32'h900,0);
    @(posedge CLK);
    #1 drive(0,0,0, 0,0,0, 0, F);
    #3 chk_bus("rst_after", 0,0,0,0, 0,0);

`ifdef ARB_FAIR_EN
    fair_addr = '{32'h0, 32'h700, 32'h0, 32'h700, 32'h0, 32'h700, 32'h0, 32'h700,
                  32'h0, 32'h800, 32'h0, 32'h700};
`else
    fair_addr = '{32'h0, 32'h700, 32'h0, 32'h700, 32'h0, 32'h700, 32'h0, 32'h700,
                  32'h0, 32'h700, 32'h0, 32'h700};
`endif
    for (int c = 0; c < 12; c++) begin
      @(posedge CLK);
      #1 drive(1,0,1, 32'h700,0,32'h800, 32'h0F0F0000 + c, A);
      #3 chk($sformatf("fair_c%0d_ramaddr", c), ramaddr, fair_addr[c]);
    end
    @(posedge CLK);
    #1 drive(0,0,0, 0,0,0, 0, F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
